// File: rtl/usr_pkg.sv
// usr_pkg: shared select, direction and state encodings for the universal shift register.
package usr_pkg;
    localparam logic [1:0] SEL_HOLD = 2'b00;
    localparam logic [1:0] SEL_SHR  = 2'b01;
    localparam logic [1:0] SEL_SHL  = 2'b10;
    localparam logic [1:0] SEL_LOAD = 2'b11;
    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;
    typedef enum logic {ST_IDLE, ST_RUN} state_t;
endpackage

// File: rtl/usr_shift_step.sv
// usr_shift_step: combinational next-value of the register for one hold/shift/load operation.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [1:0]       op_i,
    input  logic             rotate_i,
    input  logic             si_msb_i,
    input  logic             si_lsb_i,
    input  logic [WIDTH-1:0] d_in_i,
    output logic [WIDTH-1:0] q_o
);
    logic fill_r, fill_l;
    always_comb begin
        fill_r = rotate_i ? q_i[0] : si_msb_i;
        fill_l = rotate_i ? q_i[WIDTH-1] : si_lsb_i;
        q_o = op_i == SEL_SHR  ? {fill_r, q_i[WIDTH-1:1]} :
              op_i == SEL_SHL  ? {q_i[WIDTH-2:0], fill_l} :
              op_i == SEL_LOAD ? d_in_i : q_i;
    end
endmodule

// File: rtl/usr_nbit_seq.sv
// usr_nbit_seq: N-bit universal shift register with direct select control
// and an auto-step engine that performs K shifts/rotates per start pulse.
module usr_nbit_seq
    import usr_pkg::*;
#(
    parameter int  WIDTH = 8,
    localparam int AMT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       select,
    input  logic             rotate,
    input  logic             si_msb,
    input  logic             si_lsb,
    input  logic [WIDTH-1:0] d_in,
    input  logic             start,
    input  logic             dir,
    input  logic [AMT_W-1:0] amt,
    output logic [WIDTH-1:0] q,
    output logic             so_msb,
    output logic             so_lsb,
    output logic             busy,
    output logic             done
);
    state_t state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [AMT_W-1:0] cnt_q, cnt_d, amt_c;
    logic dir_q, dir_d, rot_q, rot_d, done_q, done_d;
    logic [1:0] op;
    logic rot;
    logic run;

    assign run   = state_q == ST_RUN;
    assign amt_c = amt > AMT_W'(WIDTH) ? AMT_W'(WIDTH) : amt;
    // A start in IDLE only latches the sequence, so the register holds that cycle.
    assign op    = run ? (dir_q == DIR_LEFT ? SEL_SHL : SEL_SHR) : (start ? SEL_HOLD : select);
    assign rot   = run ? rot_q : rotate;

    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_q),
        .op_i     (op),
        .rotate_i (rot),
        .si_msb_i (si_msb),
        .si_lsb_i (si_lsb),
        .d_in_i   (d_in),
        .q_o      (q_d)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dir_d   = dir_q;
        rot_d   = rot_q;
        done_d  = 1'b0;
        if (run) begin
            cnt_d = cnt_q - AMT_W'(1);
            if (cnt_q == AMT_W'(1)) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end else if (start) begin
            dir_d   = dir;
            rot_d   = rotate;
            cnt_d   = amt_c;
            done_d  = amt_c == '0;
            state_d = amt_c == '0 ? ST_IDLE : ST_RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            cnt_q   <= '0;
            dir_q   <= 1'b0;
            rot_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
            rot_q   <= rot_d;
            done_q  <= done_d;
        end
    end

    assign q      = q_q;
    assign so_msb = q_q[WIDTH-1];
    assign so_lsb = q_q[0];
    assign busy   = run;
    assign done   = done_q;
endmodule

// File: tb/tb_usr_nbit_seq.sv
// tb_usr_nbit_seq: directed vector table plus randomized run against a queue-based reference model.
module tb_usr_nbit_seq;
    localparam int W  = 8;
    localparam int AW = $clog2(W + 1);

    logic clk = 1'b0;
    logic rst, rotate, si_msb, si_lsb, start, dir;
    logic [1:0] select;
    logic [W-1:0] d_in;
    logic [AW-1:0] amt;
    logic [W-1:0] q;
    logic so_msb, so_lsb, busy, done;

    int errs = 0;
    int checks = 0;

    always #5 clk = ~clk;

    usr_nbit_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .select(select), .rotate(rotate), .si_msb(si_msb),
        .si_lsb(si_lsb), .d_in(d_in), .start(start), .dir(dir), .amt(amt),
        .q(q), .so_msb(so_msb), .so_lsb(so_lsb), .busy(busy), .done(done)
    );

    typedef struct {
        logic rst; logic [1:0] sel; logic rot; logic sim; logic sil;
        logic [7:0] d; logic st; logic dr; logic [3:0] amt;
        logic [7:0] eq; logic eb; logic ed;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t v(input logic r, input logic [1:0] s, input logic ro, input logic sm,
                               input logic sl, input logic [7:0] d, input logic st, input logic dr,
                               input logic [3:0] a, input logic [7:0] eq, input logic eb, input logic ed);
        vec_t x;
        x.rst = r; x.sel = s; x.rot = ro; x.sim = sm; x.sil = sl; x.d = d;
        x.st = st; x.dr = dr; x.amt = a; x.eq = eq; x.eb = eb; x.ed = ed;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference shift written as plain arithmetic on the integer value.
    function automatic logic [W-1:0] sh(input logic [W-1:0] x, input bit left, input bit rot, input bit sin);
        int v0, f;
        v0 = int'(x);
        if (left) begin
            f = rot ? v0 / (1 << (W - 1)) : int'(sin);
            return W'((v0 * 2) % (1 << W) + f);
        end
        f = rot ? v0 % 2 : int'(sin);
        return W'(v0 / 2 + f * (1 << (W - 1)));
    endfunction

    logic [W-1:0] mq;
    bit mdone;
    bit [1:0] pend[$];

    task automatic model_step();
        bit [1:0] p;
        int n;
        mdone = 0;
        if (rst) begin
            mq = '0;
            pend.delete();
        end else if (pend.size() != 0) begin
            p = pend.pop_front();
            mq = sh(mq, p[1], p[0], p[1] ? si_lsb : si_msb);
            mdone = pend.size() == 0;
        end else if (start) begin
            n = int'(amt) > W ? W : int'(amt);
            for (int k = 0; k < n; k++) pend.push_back({dir, rotate});
            mdone = n == 0;
        end else if (select == 2'b01) mq = sh(mq, 0, rotate, si_msb);
        else if (select == 2'b10) mq = sh(mq, 1, rotate, si_lsb);
        else if (select == 2'b11) mq = d_in;
    endtask

    initial begin
        // Reset with competing inputs, direct load/shift
        tv.push_back(v(1, 3, 0, 0, 0, 8'hFF, 1, 0, 4'd3, 8'h00, 0, 0));
        tv.push_back(v(1, 3, 0, 0, 0, 8'hFF, 1, 0, 4'd3, 8'h00, 0, 0));
        tv.push_back(v(0, 3, 0, 0, 0, 8'hA5, 0, 0, 4'd0, 8'hA5, 0, 0));
        tv.push_back(v(0, 1, 0, 1, 0, 8'h00, 0, 0, 4'd0, 8'hD2, 0, 0));
        tv.push_back(v(0, 2, 1, 0, 0, 8'h00, 0, 0, 4'd0, 8'hA5, 0, 0));
        // Auto rotate left by 3
        tv.push_back(v(0, 3, 0, 0, 0, 8'h81, 0, 0, 4'd0, 8'h81, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 8'h00, 1, 1, 4'd3, 8'h81, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h03, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h06, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 0));
        // amt=0
        tv.push_back(v(0, 3, 0, 0, 0, 8'h00, 1, 0, 4'd0, 8'h0C, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h0C, 0, 0));
        // amt=15 clamps to 8: rotate right returns original
        tv.push_back(v(0, 3, 0, 0, 0, 8'h5A, 0, 0, 4'd0, 8'h5A, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 8'h00, 1, 0, 4'd15, 8'h5A, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h2D, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h96, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h4B, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'hA5, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'hD2, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h69, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'hB4, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h5A, 0, 1));
        // Ignored select/d_in/start during RUN, serial fill on left shift
        tv.push_back(v(0, 3, 0, 0, 0, 8'h0F, 0, 0, 4'd0, 8'h0F, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 1, 8'h00, 1, 1, 4'd4, 8'h0F, 1, 0));
        tv.push_back(v(0, 3, 1, 0, 1, 8'h00, 1, 0, 4'd2, 8'h1F, 1, 0));
        tv.push_back(v(0, 3, 1, 0, 1, 8'h00, 1, 0, 4'd2, 8'h3F, 1, 0));
        tv.push_back(v(0, 3, 1, 0, 1, 8'h00, 1, 0, 4'd2, 8'h7F, 1, 0));
        tv.push_back(v(0, 3, 1, 0, 1, 8'h00, 0, 0, 4'd2, 8'hFF, 0, 1));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'hFF, 0, 0));
        // Reset on the second RUN cycle
        tv.push_back(v(0, 3, 0, 0, 0, 8'h33, 0, 0, 4'd0, 8'h33, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 1, 0, 4'd4, 8'h33, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h19, 1, 0));
        tv.push_back(v(1, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h00, 0, 0));
        tv.push_back(v(0, 3, 0, 0, 0, 8'hC3, 0, 0, 4'd0, 8'hC3, 0, 0));
        tv.push_back(v(0, 0, 1, 0, 0, 8'h00, 1, 1, 4'd2, 8'hC3, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h87, 1, 0));
        tv.push_back(v(0, 0, 0, 0, 0, 8'h00, 0, 0, 4'd0, 8'h0F, 0, 1));
        // Back-to-back start while done is high
        tv.push_back(v(0, 0, 0, 1, 0, 8'h00, 1, 0, 4'd1, 8'h0F, 1, 0));
        tv.push_back(v(0, 0, 0, 1, 0, 8'h00, 0, 0, 4'd0, 8'h87, 0, 1));

        foreach (tv[i]) begin
            rst = tv[i].rst; select = tv[i].sel; rotate = tv[i].rot; si_msb = tv[i].sim;
            si_lsb = tv[i].sil; d_in = tv[i].d; start = tv[i].st; dir = tv[i].dr; amt = tv[i].amt;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d q", i), q, tv[i].eq);
            chk($sformatf("vec%0d busy", i), W'(busy), W'(tv[i].eb));
            chk($sformatf("vec%0d done", i), W'(done), W'(tv[i].ed));
        end

        for (int i = 0; i < 800; i++) begin
            rst    = (i == 0) || ($urandom_range(0, 59) == 0);
            select = 2'($urandom_range(0, 3));
            rotate = 1'($urandom_range(0, 1));
            si_msb = 1'($urandom_range(0, 1));
            si_lsb = 1'($urandom_range(0, 1));
            d_in   = W'($urandom);
            start  = $urandom_range(0, 4) == 0;
            dir    = 1'($urandom_range(0, 1));
            amt    = AW'($urandom_range(0, 15));
            model_step();
            @(posedge clk);
            #1;
            chk($sformatf("rnd%0d q", i), q, mq);
            chk($sformatf("rnd%0d busy", i), W'(busy), W'(pend.size() != 0));
            chk($sformatf("rnd%0d done", i), W'(done), W'(mdone));
            chk($sformatf("rnd%0d so_msb", i), W'(so_msb), W'(mq[W-1]));
            chk($sformatf("rnd%0d so_lsb", i), W'(so_lsb), W'(mq[0]));
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
